// File: rtl/corescore_stream_arbiter.sv
// Packet-level round-robin arbiter: N AXI-stream byte sources share one sink, and the grant is held from a packet's first beat to its tlast.
// Optional idle-timeout release is enabled by defining CORESCORE_ARB_TIMEOUT_EN.
module corescore_stream_arbiter #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N*W-1:0] i_tdata,
    input  logic [N-1:0]   i_tlast,
    input  logic [N-1:0]   i_tvalid,
    output logic [N-1:0]   o_tready,
    output logic [W-1:0]   o_tdata,
    output logic           o_tlast,
    output logic           o_tvalid,
    input  logic           i_tready,
    output logic [N-1:0]   o_grant,
    output logic           o_timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        LOCK
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] sel;
    logic          lock;
    logic          pkt_end;
    logic          release_now;

    if (N < 2 || W < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("corescore_stream_arbiter: need N>=2, W>=1, TIMEOUT>=1");
    end

    // Round-robin pick: walking the distance downward means the nearest
    // requester after ptr is the one that is written last and therefore wins.
    always_comb begin
        // NOTE: a default on every path keeps always_comb from inferring a latch.
        sel = ptr;
        for (int i = N; i >= 1; i--) begin
            if (i_tvalid[(int'(ptr) + i) % N]) begin
                sel = PW'((int'(ptr) + i) % N);
            end
        end
    end

    assign lock     = (state == LOCK);
    assign o_tdata  = i_tdata[int'(gidx)*W +: W];
    assign o_tlast  = lock & i_tlast[gidx];
    assign o_tvalid = lock & i_tvalid[gidx];
    assign o_tready = {N{lock & i_tready}} & o_grant;
    assign pkt_end  = o_tvalid & i_tready & i_tlast[gidx];

`ifdef CORESCORE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] idle_cnt;
    logic          timeout_hit;
    logic          timeout_q;

    assign timeout_hit = lock & ~i_tvalid[gidx] & (idle_cnt == CW'(TIMEOUT));
    assign release_now = pkt_end | timeout_hit;
    assign o_timeout   = timeout_q;
`else
    assign release_now = pkt_end;
    assign o_timeout   = 1'b0;
`endif

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_grant <= '0;
            ptr     <= PW'(N - 1);
            gidx    <= '0;
`ifdef CORESCORE_ARB_TIMEOUT_EN
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|i_tvalid) begin
                        o_grant <= {{(N-1){1'b0}}, 1'b1} << sel;
                        gidx    <= sel;
                        state   <= LOCK;
                    end
                end
                LOCK: begin
                    if (release_now) begin
                        o_grant <= '0;
                        ptr     <= gidx;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_grant <= '0;
                    state   <= IDLE;
                end
            endcase
`ifdef CORESCORE_ARB_TIMEOUT_EN
            timeout_q <= timeout_hit;
            // Counts consecutive cycles the owner has nothing to offer.
            if (!lock || i_tvalid[gidx] || release_now) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Directed bench for corescore_stream_arbiter: behavioural sources feed packets, a per-cycle log is compared against hand-derived timelines.
// Covers the CORESCORE_ARB_TIMEOUT_EN build (TIMEOUT=4) and the default build.
module tb_corescore_stream_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           i_rst_n;
    logic [N*W-1:0] i_tdata;
    logic [N-1:0]   i_tlast;
    logic [N-1:0]   i_tvalid;
    logic [N-1:0]   o_tready;
    logic [W-1:0]   o_tdata;
    logic           o_tlast;
    logic           o_tvalid;
    logic           i_tready;
    logic [N-1:0]   o_grant;
    logic           o_timeout;

    int total = 0;
    int bad   = 0;

    // Source model: per-requester beat memory {tlast, tdata}
    logic [W:0] src_mem [N][8];
    int         src_len [N];
    int         src_rd  [N];
    int         en_at   [N];
    int         rst_cyc;
    bit         rdy_toggle;

    // Per-cycle log
    logic [N-1:0] cyc_grant [128];
    logic         cyc_valid [128];
    logic [N-1:0] cyc_ready [128];
    logic         cyc_to    [128];
    int           b_cyc  [64];
    int           b_src  [64];
    logic [W-1:0] b_data [64];
    logic         b_last [64];
    int           n_beats;

    always #5 clk = ~clk;

    corescore_stream_arbiter #(.N(N), .W(W), .TIMEOUT(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .i_tready (i_tready),
        .o_grant  (o_grant),
        .o_timeout(o_timeout)
    );

    task automatic clear_src();
        for (int k = 0; k < N; k++) begin
            src_len[k] = 0;
            src_rd[k]  = 0;
            en_at[k]   = 0;
        end
        for (int i = 0; i < 64; i++) begin
            b_cyc[i] = -1;
            b_src[i] = -1;
        end
        rst_cyc    = -1;
        rdy_toggle = 1'b0;
        n_beats    = 0;
    endtask

    task automatic push(input int k, input logic [W-1:0] d, input logic l);
        src_mem[k][src_len[k]] = {l, d};
        src_len[k]++;
    endtask

    task automatic do_reset();
        clear_src();
        i_rst_n  = 1'b0;
        i_tvalid = '0;
        i_tlast  = '0;
        i_tdata  = '0;
        i_tready = 1'b1;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic drive(input int c);
        logic [W:0] head;
        for (int k = 0; k < N; k++) begin
            head = '0;
            i_tvalid[k] = 1'b0;
            if (c >= en_at[k] && src_rd[k] < src_len[k]) begin
                head        = src_mem[k][src_rd[k]];
                i_tvalid[k] = 1'b1;
            end
            i_tdata[k*W +: W] = head[W-1:0];
            i_tlast[k]        = head[W];
        end
        i_tready = rdy_toggle ? (c % 2 == 0) : 1'b1;
        i_rst_n  = (c != rst_cyc);
    endtask

    task automatic run(input int ncyc);
        logic [N-1:0] popmask;
        int           s;
        for (int c = 0; c < ncyc; c++) begin
            drive(c);
            @(negedge clk);
            cyc_grant[c] = o_grant;
            cyc_valid[c] = o_tvalid;
            cyc_ready[c] = o_tready;
            cyc_to[c]    = o_timeout;
            if (o_tvalid && i_tready && n_beats < 64) begin
                s = -1;
                for (int k = 0; k < N; k++) if (o_tready[k]) s = k;
                b_cyc[n_beats]  = c;
                b_src[n_beats]  = s;
                b_data[n_beats] = o_tdata;
                b_last[n_beats] = o_tlast;
                n_beats++;
            end
            popmask = o_tready & i_tvalid;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) if (popmask[k]) src_rd[k]++;
        end
    endtask

    task automatic test_reset();
        i_rst_n  = 1'b0;
        i_tvalid = '1;
        i_tlast  = '1;
        i_tdata  = '1;
        i_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", o_grant); end
        total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", o_tvalid); end
        total++; if (o_tready !== 4'b0000) begin bad++; $display("FAIL reset_tready got=%b want=0000", o_tready); end
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", o_timeout); end
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        logic [W-1:0] ed [3] = '{8'h41, 8'h42, 8'h43};
        do_reset();
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        run(6);
        total++; if (cyc_grant[0] !== 4'b0000) begin bad++; $display("FAIL single_bubble_grant got=%b want=0000", cyc_grant[0]); end
        total++; if (cyc_valid[0] !== 1'b0) begin bad++; $display("FAIL single_bubble_valid got=%b want=0", cyc_valid[0]); end
        total++; if (cyc_grant[1] !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", cyc_grant[1]); end
        total++; if (n_beats !== 3) begin bad++; $display("FAIL single_beats got=%0d want=3", n_beats); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (b_cyc[i] !== i + 1 || b_src[i] !== 0 || b_data[i] !== ed[i] || b_last[i] !== (i == 2)) begin
                bad++;
                $display("FAIL single_beat%0d got cyc=%0d src=%0d data=%h last=%b want cyc=%0d src=0 data=%h last=%b",
                         i, b_cyc[i], b_src[i], b_data[i], b_last[i], i + 1, ed[i], (i == 2));
            end
        end
        total++; if (cyc_grant[4] !== 4'b0000) begin bad++; $display("FAIL single_release got=%b want=0000", cyc_grant[4]); end
    endtask

    task automatic test_round_robin();
        int           es [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        int           ec [10] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
        logic [W-1:0] ed [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
        do_reset();
        for (int k = 0; k < N; k++) begin
            push(k, 8'(k*16 + 1), 1'b0);
            push(k, 8'(k*16 + 2), 1'b1);
        end
        push(0, 8'h03, 1'b0);
        push(0, 8'h04, 1'b1);
        run(16);
        total++; if (n_beats !== 10) begin bad++; $display("FAIL rr_beats got=%0d want=10", n_beats); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (b_cyc[i] !== ec[i] || b_src[i] !== es[i] || b_data[i] !== ed[i] || b_last[i] !== (i % 2 == 1)) begin
                bad++;
                $display("FAIL rr_beat%0d got cyc=%0d src=%0d data=%h last=%b want cyc=%0d src=%0d data=%h last=%b",
                         i, b_cyc[i], b_src[i], b_data[i], b_last[i], ec[i], es[i], ed[i], (i % 2 == 1));
            end
        end
        total++; if (cyc_grant[3] !== 4'b0000 || cyc_grant[6] !== 4'b0000) begin bad++; $display("FAIL rr_gap got=%b,%b want=0000,0000", cyc_grant[3], cyc_grant[6]); end
        total++; if (cyc_grant[7] !== 4'b0100) begin bad++; $display("FAIL rr_grant2 got=%b want=0100", cyc_grant[7]); end
    endtask

    task automatic test_backpressure();
        logic others_low;
        do_reset();
        rdy_toggle = 1'b1;
        push(2, 8'hAA, 1'b0);
        push(2, 8'hBB, 1'b1);
        run(8);
        others_low = 1'b1;
        for (int c = 0; c < 8; c++) if (cyc_ready[c][0] || cyc_ready[c][1] || cyc_ready[c][3]) others_low = 1'b0;
        total++; if (others_low !== 1'b1) begin bad++; $display("FAIL bp_others_ready got=%b want=1", others_low); end
        total++; if (cyc_valid[1] !== 1'b1 || cyc_ready[1] !== 4'b0000) begin bad++; $display("FAIL bp_stall got valid=%b ready=%b want valid=1 ready=0000", cyc_valid[1], cyc_ready[1]); end
        total++; if (cyc_ready[2] !== 4'b0100) begin bad++; $display("FAIL bp_ready2 got=%b want=0100", cyc_ready[2]); end
        total++; if (n_beats !== 2) begin bad++; $display("FAIL bp_beats got=%0d want=2", n_beats); end
        total++; if (b_cyc[0] !== 2 || b_data[0] !== 8'hAA || b_src[0] !== 2) begin bad++; $display("FAIL bp_beat0 got cyc=%0d src=%0d data=%h want cyc=2 src=2 data=aa", b_cyc[0], b_src[0], b_data[0]); end
        total++; if (b_cyc[1] !== 4 || b_data[1] !== 8'hBB || b_last[1] !== 1'b1) begin bad++; $display("FAIL bp_beat1 got cyc=%0d data=%h last=%b want cyc=4 data=bb last=1", b_cyc[1], b_data[1], b_last[1]); end
        total++; if (cyc_grant[5] !== 4'b0000) begin bad++; $display("FAIL bp_release got=%b want=0000", cyc_grant[5]); end
    endtask

    task automatic test_pointer_order();
        int es [8] = '{3, 3, 3, 3, 0, 0, 1, 1};
        int ec [8] = '{1, 2, 3, 4, 6, 7, 9, 10};
        do_reset();
        for (int i = 0; i < 4; i++) push(3, 8'(8'h30 + i), (i == 3));
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b1);
        push(0, 8'h00, 1'b0);
        push(0, 8'h01, 1'b1);
        en_at[1] = 2;
        en_at[0] = 3;
        run(12);
        total++; if (cyc_ready[3] !== 4'b1000) begin bad++; $display("FAIL ptr_lock_ready got=%b want=1000", cyc_ready[3]); end
        total++; if (n_beats !== 8) begin bad++; $display("FAIL ptr_beats got=%0d want=8", n_beats); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (b_cyc[i] !== ec[i] || b_src[i] !== es[i]) begin
                bad++;
                $display("FAIL ptr_beat%0d got cyc=%0d src=%0d want cyc=%0d src=%0d", i, b_cyc[i], b_src[i], ec[i], es[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        push(1, 8'h51, 1'b1);
        for (int i = 0; i < 4; i++) push(2, 8'(8'h60 + i), (i == 3));
        push(0, 8'h70, 1'b1);
        en_at[0] = 4;
        rst_cyc  = 4;
        run(8);
        total++; if (b_cyc[2] !== 4 || b_src[2] !== 2 || b_data[2] !== 8'h61) begin bad++; $display("FAIL rst_mid_beat2 got cyc=%0d src=%0d data=%h want cyc=4 src=2 data=61", b_cyc[2], b_src[2], b_data[2]); end
        total++; if (cyc_valid[5] !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", cyc_valid[5]); end
        total++; if (cyc_grant[5] !== 4'b0000) begin bad++; $display("FAIL rst_mid_grant got=%b want=0000", cyc_grant[5]); end
        total++; if (cyc_grant[6] !== 4'b0001) begin bad++; $display("FAIL rst_mid_restart got=%b want=0001", cyc_grant[6]); end
        total++; if (b_cyc[3] !== 6 || b_src[3] !== 0 || b_data[3] !== 8'h70) begin bad++; $display("FAIL rst_mid_req0 got cyc=%0d src=%0d data=%h want cyc=6 src=0 data=70", b_cyc[3], b_src[3], b_data[3]); end
    endtask

`ifdef CORESCORE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int pulses;
        do_reset();
        push(1, 8'h81, 1'b0);
        push(2, 8'h92, 1'b1);
        run(10);
        pulses = 0;
        for (int c = 0; c < 10; c++) if (cyc_to[c] === 1'b1) pulses++;
        total++; if (cyc_grant[6] !== 4'b0010 || cyc_to[6] !== 1'b0) begin bad++; $display("FAIL to_before got grant=%b to=%b want grant=0010 to=0", cyc_grant[6], cyc_to[6]); end
        total++; if (cyc_to[7] !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", cyc_to[7]); end
        total++; if (cyc_grant[7] !== 4'b0000) begin bad++; $display("FAIL to_release got=%b want=0000", cyc_grant[7]); end
        total++; if (pulses !== 1) begin bad++; $display("FAIL to_pulse_count got=%0d want=1", pulses); end
        total++; if (cyc_grant[8] !== 4'b0100) begin bad++; $display("FAIL to_next_grant got=%b want=0100", cyc_grant[8]); end
        total++; if (n_beats !== 2 || b_cyc[1] !== 8 || b_src[1] !== 2 || b_data[1] !== 8'h92) begin bad++; $display("FAIL to_req2_beat got n=%0d cyc=%0d src=%0d data=%h want n=2 cyc=8 src=2 data=92", n_beats, b_cyc[1], b_src[1], b_data[1]); end
    endtask
`else
    task automatic test_no_timeout();
        int pulses;
        logic held;
        do_reset();
        push(1, 8'h81, 1'b0);
        push(2, 8'h92, 1'b1);
        run(101);
        pulses = 0;
        held   = 1'b1;
        for (int c = 0; c <= 100; c++) begin
            if (cyc_to[c] !== 1'b0) pulses++;
            if (c >= 1 && cyc_grant[c] !== 4'b0010) held = 1'b0;
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL nto_held got=%b want=1", held); end
        total++; if (pulses !== 0) begin bad++; $display("FAIL nto_pulses got=%0d want=0", pulses); end
        total++; if (n_beats !== 1 || b_src[0] !== 1) begin bad++; $display("FAIL nto_beats got n=%0d src=%0d want n=1 src=1", n_beats, b_src[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_pointer_order();
        test_reset_mid_packet();
`ifdef CORESCORE_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
